// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with iterative multiply/divide.
// Single-cycle ops land in the output register on the accepting edge.
// MUL (shift-add) and DIV/MOD (restoring) take WIDTH iteration cycles.
module alu_seq #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   input  logic [3:0]       operation,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             zero_out,
   output logic             div_zero,
   output logic             illegal
);

   localparam int unsigned    CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, MUL_IT, DIV_IT, DONE} state_t;

   typedef enum logic [3:0] {
      OP_ADD = 4'h0, OP_SUB = 4'h1, OP_MUL = 4'h2, OP_DIV = 4'h3,
      OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_SFT = 4'h7,
      OP_EQU = 4'h8, OP_NEQ = 4'h9, OP_GTH = 4'hA, OP_LTH = 4'hB,
      OP_MOD = 4'hC
   } op_t;

   state_t             state, state_nxt;
   logic               ready_en;
   logic               accept, go_mul, go_div;
   logic [CW-1:0]      cnt;

   // iteration datapath
   logic [2*WIDTH-1:0] acc, acc_nxt;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   quo, rem, dvsr, quo_nxt, rem_nxt;
   logic [WIDTH:0]     shl, diff;
   logic               is_mod;

   // single-cycle results
   logic [WIDTH-1:0]   sc_res, sft_tmp;
   logic [WIDTH:0]     sum;
   logic               sc_carry, sc_dz, sc_ill;

   // output registers
   logic [WIDTH-1:0]   res_q;
   logic               carry_q, zero_q, dz_q, ill_q;

   assign result    = res_q;
   assign carry_out = carry_q;
   assign zero_out  = zero_q;
   assign div_zero  = dz_q;
   assign illegal   = ill_q;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Handshake decode and next-state selection
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: in_ready = ready_en;
         DONE: begin
            out_valid = 1'b1;
            in_ready  = ready_en & out_ready;
         end
         default: ;
      endcase
      accept = in_valid & in_ready;
      go_mul = accept & (operation == OP_MUL);
      go_div = accept & ((operation == OP_DIV) | (operation == OP_MOD)) & (op2 != '0);
      case (state)
         IDLE: begin
            if (accept) state_nxt = go_mul ? MUL_IT : (go_div ? DIV_IT : DONE);
         end
         MUL_IT, DIV_IT: begin
            if (cnt == LAST) state_nxt = DONE;
         end
         DONE: begin
            if (out_ready) begin
               if (accept) state_nxt = go_mul ? MUL_IT : (go_div ? DIV_IT : DONE);
               else        state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Results for every op that completes on the accepting edge
   always_comb begin
      sc_res   = '0;
      sc_carry = 1'b0;
      sc_dz    = 1'b0;
      sc_ill   = 1'b0;
      sft_tmp  = '0;
      sum      = {1'b0, op1} + {1'b0, op2};
      case (operation)
         OP_ADD: begin
            sc_res   = sum[WIDTH-1:0];
            sc_carry = sum[WIDTH];
         end
         OP_SUB: begin
            sc_res   = op1 - op2;
            sc_carry = (op1 < op2);
         end
         OP_MUL: ;
         OP_DIV, OP_MOD: sc_dz = (op2 == '0);
         OP_AND: sc_res = op1 & op2;
         OP_OR:  sc_res = op1 | op2;
         OP_XOR: sc_res = op1 ^ op2;
         OP_SFT: begin
            sft_tmp = op1 >> op2[3:0];
            sc_res  = sft_tmp << op2[7:4];
         end
         OP_EQU: sc_res[0] = (op1 == op2);
         OP_NEQ: sc_res[0] = (op1 != op2);
         OP_GTH: sc_res[0] = (op1 > op2);
         OP_LTH: sc_res[0] = (op1 < op2);
         default: sc_ill = 1'b1;
      endcase
   end

   // One shift-add step and one restoring-divide step
   always_comb begin
      mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
      acc_nxt = {mul_sum, acc[WIDTH-1:1]};
      shl     = {rem, quo[WIDTH-1]};
      diff    = shl - {1'b0, dvsr};
      rem_nxt = diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], ~diff[WIDTH]};
   end

   // Operand capture, iteration registers and output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en <= 1'b0;
         cnt      <= '0;
         acc      <= '0;
         mcand    <= '0;
         quo      <= '0;
         rem      <= '0;
         dvsr     <= '0;
         is_mod   <= 1'b0;
         res_q    <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
         dz_q     <= 1'b0;
         ill_q    <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         if (go_mul) begin
            acc   <= {{WIDTH{1'b0}}, op1};
            mcand <= op2;
            cnt   <= '0;
         end else if (go_div) begin
            quo    <= op1;
            rem    <= '0;
            dvsr   <= op2;
            is_mod <= (operation == OP_MOD);
            cnt    <= '0;
         end else if (accept) begin
            res_q   <= sc_res;
            carry_q <= sc_carry;
            zero_q  <= (sc_res == '0);
            dz_q    <= sc_dz;
            ill_q   <= sc_ill;
         end else if (state == MUL_IT) begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
               res_q   <= acc_nxt[WIDTH-1:0];
               carry_q <= |acc_nxt[2*WIDTH-1:WIDTH];
               zero_q  <= (acc_nxt[WIDTH-1:0] == '0);
               dz_q    <= 1'b0;
               ill_q   <= 1'b0;
            end
         end else if (state == DIV_IT) begin
            quo <= quo_nxt;
            rem <= rem_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
               res_q   <= is_mod ? rem_nxt : quo_nxt;
               carry_q <= 1'b0;
               zero_q  <= ((is_mod ? rem_nxt : quo_nxt) == '0);
               dz_q    <= 1'b0;
               ill_q   <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: WIDTH=8 instance driven from a vector table, hand
// sequences and random ops through a scoreboard; WIDTH=16 instance for MUL.
module tb_alu_seq;

   typedef struct packed {
      logic [3:0] op;
      logic [7:0] a, b, res;
      logic       c, z, dz, il;
      logic [7:0] lat;
   } vec_t;

   typedef struct packed {
      vec_t        v;
      logic [31:0] acc;
   } sb_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        in_valid, in_ready, out_valid, out_ready;
   logic [7:0]  op1, op2, result;
   logic [3:0]  operation;
   logic        carry_out, zero_out, div_zero, illegal;

   logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
   logic [15:0] w_op1, w_op2, w_result;
   logic [3:0]  w_operation;
   logic        w_carry, w_zero, w_dz, w_ill;

   int unsigned errors = 0;
   int unsigned checks = 0;
   int unsigned cyc = 0;
   sb_t         sb[$];
   int unsigned pop_cyc[$];
   bit          seen = 1'b0;
   bit          rnd_busy = 1'b0;
   vec_t        tbl[$];

   alu_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op1(op1), .op2(op2), .operation(operation), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .carry_out(carry_out),
      .zero_out(zero_out), .div_zero(div_zero), .illegal(illegal)
   );

   alu_seq #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
      .op1(w_op1), .op2(w_op2), .operation(w_operation), .out_valid(w_out_valid),
      .out_ready(w_out_ready), .result(w_result), .carry_out(w_carry),
      .zero_out(w_zero), .div_zero(w_dz), .illegal(w_ill)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] r, input logic c, input logic z,
                               input logic dz, input logic il, input logic [7:0] lat);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.res = r;
      v.c = c; v.z = z; v.dz = dz; v.il = il; v.lat = lat;
      return v;
   endfunction

   // Reference behaviour for random vectors
   function automatic vec_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      vec_t        v;
      logic [8:0]  s;
      logic [15:0] p;
      logic [3:0]  ra, la;
      v = mk(op, a, b, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
      case (op)
         4'h0: begin s = {1'b0, a} + {1'b0, b}; v.res = s[7:0]; v.c = s[8]; end
         4'h1: begin v.res = a - b; v.c = (a < b); end
         4'h2: begin p = {8'h00, a} * {8'h00, b}; v.res = p[7:0]; v.c = (p[15:8] != 0); v.lat = 8'd9; end
         4'h3: if (b == 0) v.dz = 1'b1; else begin v.res = a / b; v.lat = 8'd9; end
         4'h4: v.res = a & b;
         4'h5: v.res = a | b;
         4'h6: v.res = a ^ b;
         4'h7: begin
            ra = b[3:0]; la = b[7:4];
            if (ra >= 8 || la >= 8) v.res = 8'h00;
            else v.res = 8'((a >> ra) << la);
         end
         4'h8: v.res = {7'd0, a == b};
         4'h9: v.res = {7'd0, a != b};
         4'hA: v.res = {7'd0, a > b};
         4'hB: v.res = {7'd0, a < b};
         4'hC: if (b == 0) v.dz = 1'b1; else begin v.res = a % b; v.lat = 8'd9; end
         default: v.il = 1'b1;
      endcase
      v.z = (v.res == 8'h00);
      return v;
   endfunction

   // Drive one transaction; push its expectation when it is accepted
   task automatic send(input vec_t v);
      int unsigned n;
      sb_t e;
      @(negedge clk);
      in_valid = 1'b1; operation = v.op; op1 = v.a; op2 = v.b;
      #1;
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk); #1; n++;
      end
      if (!in_ready) begin
         check("accept_timeout", 64'(in_ready), 64'(1));
      end else begin
         @(posedge clk); #1;
         e.v = v; e.acc = cyc;
         sb.push_back(e);
      end
      in_valid = 1'b0;
      op1 = 8'($urandom); op2 = 8'($urandom); operation = 4'($urandom);
   endtask

   task automatic drain();
      int unsigned n;
      n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge clk); n++;
      end
      #3;
      check("drain_empty", 64'(sb.size()), 64'(0));
      sb.delete();
      seen = 1'b0;
   endtask

   // Output monitor: compares the head of the scoreboard every valid cycle
   initial begin : mon
      sb_t e;
      forever begin
         @(negedge clk); #2;
         if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
               check("spurious_out_valid", 64'(out_valid), 64'(0));
            end else begin
               e = sb[0];
               if (!seen) begin
                  seen = 1'b1;
                  check($sformatf("latency_op%0h", e.v.op), 64'(cyc - e.acc + 1), 64'(e.v.lat));
               end
               check($sformatf("out_op%0h_%0h_%0h", e.v.op, e.v.a, e.v.b),
                     64'({result, carry_out, zero_out, div_zero, illegal}),
                     64'({e.v.res, e.v.c, e.v.z, e.v.dz, e.v.il}));
               if (out_ready) begin
                  void'(sb.pop_front());
                  seen = 1'b0;
                  pop_cyc.push_back(cyc);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin : main
      int unsigned acc16, n;
      logic [3:0]  rop;
      logic [7:0]  ra, rb;

      in_valid = 1'b0; out_ready = 1'b0; op1 = '0; op2 = '0; operation = '0;
      w_in_valid = 1'b0; w_out_ready = 1'b0; w_op1 = '0; w_op2 = '0; w_operation = '0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check("reset_outs8", 64'({out_valid, in_ready, result, carry_out, zero_out, div_zero, illegal}), 64'(0));
      check("reset_outs16", 64'({w_out_valid, w_in_ready, w_result, w_carry, w_zero, w_dz, w_ill}), 64'(0));
      rst_n = 1'b1;
      #1;
      check("in_ready_before_clk", 64'(in_ready), 64'(0));
      @(negedge clk); #1;
      check("in_ready_after_release", 64'(in_ready), 64'(1));

      // ADD then mid-run reset
      out_ready = 1'b1;
      send(mk(4'h0, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1));
      drain();
      @(negedge clk); #3;
      rst_n = 1'b0;
      #1;
      check("midrun_reset_outs", 64'({out_valid, in_ready, result, carry_out, zero_out, div_zero, illegal}), 64'(0));
      #1 rst_n = 1'b1;
      @(negedge clk); #1;
      check("in_ready_after_midrun", 64'(in_ready), 64'(1));

      // Vector table: op, a, b, result, carry, zero, div_zero, illegal, latency
      tbl.push_back(mk(4'h0, 8'hFF, 8'h01, 8'h00, 1, 1, 0, 0, 1));
      tbl.push_back(mk(4'h0, 8'h12, 8'h34, 8'h46, 0, 0, 0, 0, 1));
      tbl.push_back(mk(4'h1, 8'h07, 8'h05, 8'h02, 0, 0, 0, 0, 1));
      tbl.push_back(mk(4'h1, 8'h05, 8'h05, 8'h00, 0, 1, 0, 0, 1));
      tbl.push_back(mk(4'h2, 8'h0F, 8'h0F, 8'hE1, 0, 0, 0, 0, 9));
      tbl.push_back(mk(4'h2, 8'h00, 8'h37, 8'h00, 0, 1, 0, 0, 9));
      tbl.push_back(mk(4'h2, 8'hFF, 8'hFF, 8'h01, 1, 0, 0, 0, 9));
      tbl.push_back(mk(4'h3, 8'd200, 8'd7, 8'h1C, 0, 0, 0, 0, 9));
      tbl.push_back(mk(4'hC, 8'd200, 8'd7, 8'h04, 0, 0, 0, 0, 9));
      tbl.push_back(mk(4'h3, 8'h05, 8'h00, 8'h00, 0, 1, 1, 0, 1));
      tbl.push_back(mk(4'hC, 8'h09, 8'h00, 8'h00, 0, 1, 1, 0, 1));
      tbl.push_back(mk(4'h3, 8'h07, 8'd200, 8'h00, 0, 1, 0, 0, 9));
      tbl.push_back(mk(4'hC, 8'hFF, 8'h10, 8'h0F, 0, 0, 0, 0, 9));
      tbl.push_back(mk(4'h3, 8'hFF, 8'h01, 8'hFF, 0, 0, 0, 0, 9));
      tbl.push_back(mk(4'h4, 8'hCC, 8'hAA, 8'h88, 0, 0, 0, 0, 1));
      tbl.push_back(mk(4'h5, 8'hCC, 8'hAA, 8'hEE, 0, 0, 0, 0, 1));
      tbl.push_back(mk(4'h6, 8'hCC, 8'hCC, 8'h00, 0, 1, 0, 0, 1));
      tbl.push_back(mk(4'h7, 8'h34, 8'h21, 8'h68, 0, 0, 0, 0, 1));
      tbl.push_back(mk(4'h7, 8'h34, 8'h09, 8'h00, 0, 1, 0, 0, 1));
      tbl.push_back(mk(4'h7, 8'h81, 8'h80, 8'h00, 0, 1, 0, 0, 1));
      tbl.push_back(mk(4'h7, 8'hF0, 8'h04, 8'h0F, 0, 0, 0, 0, 1));
      tbl.push_back(mk(4'h7, 8'h01, 8'h70, 8'h80, 0, 0, 0, 0, 1));
      tbl.push_back(mk(4'h8, 8'h05, 8'h05, 8'h01, 0, 0, 0, 0, 1));
      tbl.push_back(mk(4'h9, 8'h05, 8'h05, 8'h00, 0, 1, 0, 0, 1));
      tbl.push_back(mk(4'hA, 8'h03, 8'h02, 8'h01, 0, 0, 0, 0, 1));
      tbl.push_back(mk(4'hB, 8'h03, 8'h02, 8'h00, 0, 1, 0, 0, 1));
      tbl.push_back(mk(4'hA, 8'h02, 8'h03, 8'h00, 0, 1, 0, 0, 1));
      tbl.push_back(mk(4'hB, 8'h02, 8'h03, 8'h01, 0, 0, 0, 0, 1));
      tbl.push_back(mk(4'hD, 8'h12, 8'h34, 8'h00, 0, 1, 0, 1, 1));
      tbl.push_back(mk(4'hE, 8'hFF, 8'hFF, 8'h00, 0, 1, 0, 1, 1));
      tbl.push_back(mk(4'hF, 8'h01, 8'h00, 8'h00, 0, 1, 0, 1, 1));
      foreach (tbl[i]) send(tbl[i]);
      drain();

      // MUL under backpressure: busy for 8 cycles, then result held while stalled
      out_ready = 1'b0;
      send(mk(4'h2, 8'h10, 8'h11, 8'h10, 1, 0, 0, 0, 9));
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); #1;
         check("mul_busy_in_ready", 64'(in_ready), 64'(0));
         check("mul_busy_out_valid", 64'(out_valid), 64'(0));
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         check("stall_out_valid", 64'(out_valid), 64'(1));
         check("stall_result", 64'({result, carry_out}), 64'({8'h10, 1'b1}));
      end
      @(negedge clk);
      out_ready = 1'b1;
      drain();

      // Back-to-back single-cycle ops
      pop_cyc.delete();
      send(mk(4'h6, 8'h5A, 8'hFF, 8'hA5, 0, 0, 0, 0, 1));
      send(mk(4'h1, 8'h05, 8'h07, 8'hFE, 1, 0, 0, 0, 1));
      send(mk(4'h4, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 0, 1));
      drain();
      check("b2b_count", 64'(pop_cyc.size()), 64'(3));
      if (pop_cyc.size() >= 3) begin
         check("b2b_gap1", 64'(pop_cyc[1] - pop_cyc[0]), 64'(1));
         check("b2b_gap2", 64'(pop_cyc[2] - pop_cyc[1]), 64'(1));
      end

      // Reset during cycle 4 of a DIV aborts it
      send(mk(4'h3, 8'd200, 8'd7, 8'h1C, 0, 0, 0, 0, 9));
      repeat (4) @(negedge clk);
      #1;
      check("abort_busy", 64'(in_ready), 64'(0));
      rst_n = 1'b0;
      sb.delete();
      seen = 1'b0;
      #1;
      check("abort_reset_outs", 64'({out_valid, in_ready, result, carry_out, zero_out, div_zero, illegal}), 64'(0));
      #1 rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk); #1;
         check("abort_no_out_valid", 64'(out_valid), 64'(0));
      end
      send(mk(4'h0, 8'h01, 8'h02, 8'h03, 0, 0, 0, 0, 1));
      drain();

      // WIDTH=16 multiply
      w_out_ready = 1'b1;
      @(negedge clk);
      w_in_valid = 1'b1; w_operation = 4'h2; w_op1 = 16'h0100; w_op2 = 16'h0100;
      #1;
      check("w16_in_ready", 64'(w_in_ready), 64'(1));
      @(posedge clk); #1;
      acc16 = cyc;
      w_in_valid = 1'b0; w_op1 = 16'hFFFF; w_op2 = 16'h1234; w_operation = 4'h0;
      n = 0;
      while (!w_out_valid && n < 60) begin
         @(negedge clk); #1; n++;
      end
      check("w16_latency", 64'(cyc - acc16 + 1), 64'(17));
      check("w16_out", 64'({w_result, w_carry, w_zero, w_dz, w_ill}), 64'({16'h0000, 1'b1, 1'b1, 1'b0, 1'b0}));
      @(negedge clk); #1;
      check("w16_valid_drop", 64'(w_out_valid), 64'(0));

      // Random ops with random backpressure
      rnd_busy = 1'b1;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               rop = 4'($urandom);
               ra = 8'($urandom);
               rb = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
               send(model(rop, ra, rb));
            end
            rnd_busy = 1'b0;
         end
         begin
            while (rnd_busy) begin
               @(negedge clk);
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      @(negedge clk);
      out_ready = 1'b1;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the 8-bit combinational ALU in the uxn-multi datapath. It accepts one operation per transaction over a valid/ready input channel and returns a registered result with flags over a valid/ready output channel. Multiply, divide and modulo run iteratively, one bit per cycle. All other operations complete in one cycle. It sits between the operand stack read stage and the writeback stage, so the core can stall on long operations without needing combinational paths for them.

## Interface
- WIDTH, default 8: operand and result width. Legal values are 8, 16, 32. uxn byte mode uses 8; short mode uses 16.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands and opcode are valid
- in_ready  out  1  block can accept a transaction this cycle
- op1, op2  in  WIDTH  operands
- operation  in  4  opcode, see Operation
- out_valid  out  1  result, carry_out, zero_out, div_zero and illegal are valid
- out_ready  in  1  consumer takes the result this cycle
- result  out  WIDTH  registered result
- carry_out  out  1  carry, borrow or overflow flag
- zero_out  out  1  result == 0
- div_zero  out  1  DIV or MOD was issued with op2 == 0
- illegal  out  1  opcode was D, E or F

## Operation
- Opcodes and their results:
  - 0 ADD: result = op1 + op2; carry_out = bit WIDTH of the sum.
  - 1 SUB: result = op1 - op2 mod 2^WIDTH; carry_out = (op1 < op2), the borrow.
  - 2 MUL: result = low WIDTH bits of the product; carry_out = (high half ≠ 0).
  - 3 DIV: unsigned quotient.
  - 4 AND, 5 OR, 6 XOR: bitwise.
  - 7 SFT: result = (op1 >> op2[3:0]) << op2[7:4]. Any shift amount ≥ WIDTH produces 0 for that step.
  - 8 EQU, 9 NEQ, A GTH, B LTH: unsigned compares; result = 1 if true, else 0.
  - C MOD: unsigned remainder.
  - D–F: result 0, illegal = 1.
- carry_out is 0 for every opcode not listed above as setting it. zero_out is always computed from the final result.
- div_zero is set only for DIV or MOD with op2 == 0. In that case result = 0 and the op takes the single-cycle path; no iteration runs.
- States:
  - IDLE: waiting for a transaction.
  - MUL_IT: shift-add multiply. Holds a 2·WIDTH accumulator, multiplicand, and a bit counter counting 0..WIDTH-1.
  - DIV_IT: restoring divide. Holds quotient, remainder and a bit counter; DIV and MOD share this state.
  - DONE: output register full, waiting for out_ready.
- Transitions:
  - IDLE to DONE on acceptance of a single-cycle op.
  - IDLE to MUL_IT or DIV_IT on acceptance of MUL, or of DIV/MOD with op2 ≠ 0.
  - MUL_IT or DIV_IT to DONE after exactly WIDTH iteration cycles.
  - DONE to IDLE when out_ready = 1.
  - DONE to DONE when out_ready = 1 and a new single-cycle op is accepted in the same cycle (back-to-back).
  - DONE to MUL_IT or DIV_IT when out_ready = 1 and a new multi-cycle op is accepted in the same cycle.
- Operands are captured at acceptance. Changes on op1, op2 or operation after acceptance have no effect.

## Timing
- Reset (rst_n low, asynchronous):
  - State goes to IDLE and counters clear.
  - result, carry_out, zero_out, div_zero, illegal and out_valid all go to 0.
  - in_ready goes to 0 while rst_n is low, and to 1 on the first clk after release.
  - Reset during MUL_IT or DIV_IT aborts the operation; no result is ever presented for it.
- in_ready = (state == IDLE) or (state == DONE and out_ready). It is low throughout MUL_IT and DIV_IT.
- Acceptance happens on a rising edge with in_valid and in_ready both high.
- Latency from acceptance edge to out_valid high:
  - 1 cycle for single-cycle ops, including div-by-zero and illegal opcodes.
  - WIDTH + 1 cycles for MUL, DIV and MOD.
- Throughput: one single-cycle op per clk when out_ready is held high.
- Output stability: result and all flags hold stable while out_valid = 1 and out_ready = 0. out_valid never drops without out_ready.
- Outputs are deasserted after a handshake. out_valid falls the cycle after out_ready if no new transaction was accepted. The result and flag registers keep their values, which are don't-care while out_valid = 0.
- in_valid without in_ready: the upstream must hold its values; the block ignores them.

## Test plan
- Reset and ADD, WIDTH=8:
  - Assert rst_n low mid-run, then release. Required: all outputs 0, then in_ready = 1.
  - ADD 0xF0 + 0x20. Required: result 0x10, carry 1, zero 0, out_valid exactly 1 cycle after accept.
- MUL and backpressure:
  - MUL 0x10 × 0x11 with out_ready = 0. Required: in_ready low for 8 cycles, out_valid at cycle 9, result 0x10, carry 1.
  - Result must hold for 5 stalled cycles until out_ready rises.
- DIV, MOD and divide by zero:
  - DIV 200 / 7. Required: 0x1C after 9 cycles.
  - MOD 200 % 7. Required: 0x04.
  - DIV 5 / 0. Required: result 0, div_zero 1, zero 1, latency 1.
- SFT and compares:
  - SFT op1 = 0x34, op2 = 0x21. Required: 0x68.
  - SFT op2 = 0x09. Required: 0x00.
  - GTH 3, 2. Required: 1.
  - LTH 3, 2. Required: 0, zero 1.
  - Opcode 0xE. Required: result 0, illegal 1.
- Back-to-back: XOR, SUB 0x05−0x07 and AND issued with out_ready held high.
  - Required: three results on consecutive cycles.
  - SUB result is 0xFE with carry 1.
- Reset abort and WIDTH=16:
  - Pulse rst_n low during cycle 4 of a DIV. Required: no out_valid for it; the next ADD completes normally.
  - WIDTH=16: MUL 0x0100 × 0x0100. Required: result 0x0000, carry 1, zero 1, latency 17.
